// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the memory-mapped UART transmitter.
//   - uart_state_e : transmit FSM state encoding
//   - REG_*        : word selects decoded from the IO address
//   - STAT_*       : bit positions inside the STATUS word
//   - even_parity  : XOR of a data byte
// Optional feature macro: UART_TX_PARITY_EN adds the ST_PARITY state.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        , ST_PARITY = 3'd4
`endif
    } uart_state_e;

    // Word selects (io_addr is byte-address bit 2).
    localparam logic REG_DATA   = 1'b0;
    localparam logic REG_STATUS = 1'b1;

    // STATUS word layout: {.., parity_en, level[3:0], overflow, busy, full, empty}
    localparam int STAT_EMPTY  = 0;
    localparam int STAT_FULL   = 1;
    localparam int STAT_BUSY   = 2;
    localparam int STAT_OVF    = 3;
    localparam int STAT_LEVEL  = 4;
    localparam int STAT_PARITY = 8;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_tx_mmio_if.sv
// uart_tx_mmio_if: processor-side IO bus of the UART transmitter.
//   io_addr  : 0 = DATA, 1 = STATUS
//   io_wstrb : 1-cycle write strobe, io_wdata[7:0] carries the byte
//   io_rstrb : read strobe, io_rdata valid the following cycle and held
// master = processor, slave = UART.
interface uart_tx_mmio_if;
    logic        io_addr;
    logic        io_wstrb;
    logic [31:0] io_wdata;
    logic        io_rstrb;
    logic [31:0] io_rdata;

    modport master (
        output io_addr, io_wstrb, io_wdata, io_rstrb,
        input  io_rdata
    );

    modport slave (
        input  io_addr, io_wstrb, io_wdata, io_rstrb,
        output io_rdata
    );
endinterface

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous FIFO with a combinational head output.
//   clk, reset : clock, asynchronous active-high reset
//   push, din  : enqueue din (ignored while full)
//   pop, dout  : dequeue; dout is the current head
//   full, empty, level : occupancy from the registered pointers
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty = (wptr_q == rptr_q);
    assign level = wptr_q - rptr_q;
    assign dout  = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
        end
    end
endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter (8N1, or 8E1 with parity).
//   clk, reset : system clock, asynchronous active-high reset
//   io         : uart_tx_mmio_if.slave -- DATA writes push the FIFO,
//                STATUS reads return {level, overflow, busy, full, empty}
//   txd        : serial line, idle high, always from a flop
//   busy       : FIFO non-empty or a frame in flight (registered)
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit
// between the data bits and the stop bit and sets STATUS bit 8.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 12000000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_mmio_if.slave io,
    output logic          txd,
    output logic          busy
);
    localparam int DIV = CLK_FREQ_HZ / BAUD;
    localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
    localparam int LW  = $clog2(FIFO_DEPTH) + 1;

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_mmio: CLK_FREQ_HZ/BAUD must be at least 2");
    end

    logic          wr_data, rd_status, drop;
    logic          fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic [LW-1:0] fifo_level;
    logic [31:0]   status_word;
    logic          baud_last;
    logic          unused_wdata;

    uart_state_e   state_q, state_d;
    logic [7:0]    sh_q, sh_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [CW-1:0] baud_q, baud_d;
    logic          txd_q, txd_d;
    logic          busy_q, busy_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   rdata_q, rdata_d;
`ifdef UART_TX_PARITY_EN
    logic          par_q, par_d;
`endif

    assign unused_wdata = ^io.io_wdata[31:8];

    // ---------------- bus decode ----------------
    assign wr_data   = io.io_wstrb && (io.io_addr == REG_DATA);
    assign rd_status = io.io_rstrb && (io.io_addr == REG_STATUS);
    // Fullness is the pre-cycle value: a same-cycle pop does not make room.
    assign drop      = wr_data && fifo_full;

    uart_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_data),
        .pop   (fifo_pop),
        .din   (io.io_wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        status_word                      = '0;
        status_word[STAT_EMPTY]          = fifo_empty;
        status_word[STAT_FULL]           = fifo_full;
        status_word[STAT_BUSY]           = busy_q;
        status_word[STAT_OVF]            = ovf_q;
        status_word[STAT_LEVEL +: 4]     = 4'(fifo_level);
`ifdef UART_TX_PARITY_EN
        status_word[STAT_PARITY]         = 1'b1;
`endif
    end

    always_comb begin
        // A drop in the sampling cycle keeps the flag set.
        ovf_d = ovf_q;
        if (rd_status) ovf_d = 1'b0;
        if (drop)      ovf_d = 1'b1;

        rdata_d = rdata_q;
        if (io.io_rstrb) rdata_d = (io.io_addr == REG_STATUS) ? status_word : 32'h0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ovf_q   <= ovf_d;
            rdata_q <= rdata_d;
        end
    end

    // ---------------- transmit FSM ----------------
    assign baud_last = (baud_q == CW'(DIV - 1));

    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        bitcnt_d = bitcnt_q;
        baud_d   = baud_q;
        fifo_pop = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d    = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    sh_d     = fifo_dout;
                    bitcnt_d = '0;
                    baud_d   = '0;
                    state_d  = ST_START;
`ifdef UART_TX_PARITY_EN
                    par_d    = even_parity(fifo_dout);
`endif
                end
            end
            ST_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    baud_d   = '0;
                    sh_d     = sh_q >> 1;
                    bitcnt_d = bitcnt_q + 3'd1;
`ifdef UART_TX_PARITY_EN
                    if (bitcnt_q == 3'd7) state_d = ST_PARITY;
`else
                    if (bitcnt_q == 3'd7) state_d = ST_STOP;
`endif
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = ST_STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                baud_d  = '0;
                state_d = ST_IDLE;
            end
        endcase

        // Line level follows the current state one cycle later, so a push
        // at edge N shows the start bit from edge N+2.
        case (state_q)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = sh_q[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: txd_d = par_q;
`endif
            default:   txd_d = 1'b1;
        endcase

        busy_d = !fifo_empty || (state_q != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            sh_q     <= '0;
            bitcnt_q <= '0;
            baud_q   <= '0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            bitcnt_q <= bitcnt_d;
            baud_q   <= baud_d;
            txd_q    <= txd_d;
            busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    assign txd         = txd_q;
    assign busy        = busy_q;
    assign io.io_rdata = rdata_q;
endmodule
